// File: rtl/vga_fb_port.sv
// Framebuffer memory with a never-stalled combinational scan-out read port and a
// CPU port whose stores and loads are serviced only while the beam is blanked.
// Stores queue in a small FIFO. Loads wait until that FIFO has drained, so a load
// never passes an older store.
module vga_fb_port #(
  parameter logic [31:0] BASE       = 32'h0000_0400,
  parameter int          WORDS      = 256,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        blank,
  input  logic [31:0] vga_raddr,
  output logic [31:0] vga_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err
);

  localparam int          IDX_W = $clog2(WORDS);
  localparam int          PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [31:0] SPAN  = 32'(4 * WORDS);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } state_t;

  // Unsigned wrap of the subtract pushes addresses below BASE far out of range.
  function automatic logic in_region(input logic [31:0] addr);
    return ((addr - BASE) < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
    return IDX_W'((addr - BASE) >> 2);
  endfunction

  logic [31:0]      mem_r [WORDS];

  logic [IDX_W-1:0] fifo_idx_r   [FIFO_DEPTH];
  logic [3:0]       fifo_be_r    [FIFO_DEPTH];
  logic [31:0]      fifo_data_r  [FIFO_DEPTH];
  logic             fifo_inreg_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;

  state_t           state_r;
  state_t           state_s;
  logic [IDX_W-1:0] ld_idx_r;
  logic             ld_inreg_r;
  logic             rvalid_r;
  logic [31:0]      rdata_r;
  logic             err_r;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             load_acc_s;
  logic             ready_s;

  assign full_s     = (count_r == FULL_CNT);
  assign empty_s    = (count_r == '0);
  assign push_s     = cpu_req && cpu_we && !full_s;
  assign pop_s      = blank && !empty_s && (state_r == IDLE);
  assign load_acc_s = cpu_req && !cpu_we && empty_s && (state_r == IDLE);

  assign cpu_ready  = ready_s;
  assign cpu_rvalid = rvalid_r;
  assign cpu_rdata  = rdata_r;
  assign cpu_err    = err_r;

  // Acceptance: stores need a free slot, loads need an empty queue and an idle load path.
  always_comb begin
    ready_s = 1'b0;
    if (cpu_we) begin
      ready_s = !full_s;
    end else begin
      ready_s = empty_s && (state_r == IDLE);
    end
  end

  // Scan-out read straight from the array, never gated by CPU activity.
  always_comb begin
    vga_rdata = 32'h0000_0000;
    if (in_region(vga_raddr)) begin
      vga_rdata = mem_r[word_index(vga_raddr)];
    end else begin
      vga_rdata = 32'h0000_0000;
    end
  end

  // Queue payload storage; only the pointers carry reset state.
  always_ff @(posedge clk50) begin
    if (push_s) begin
      fifo_idx_r[wr_ptr_r]   <= word_index(cpu_addr);
      fifo_be_r[wr_ptr_r]    <= cpu_be;
      fifo_data_r[wr_ptr_r]  <= cpu_wdata;
      fifo_inreg_r[wr_ptr_r] <= in_region(cpu_addr);
    end
  end

  // Queue pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Drain write: enabled lanes of the popped in-region entry land in the array.
  always_ff @(posedge clk50) begin
    if (pop_s && fifo_inreg_r[rd_ptr_r]) begin
      for (int i = 0; i < 4; i++) begin
        if (fifo_be_r[rd_ptr_r][i]) begin
          mem_r[fifo_idx_r[rd_ptr_r]][8*i +: 8] <= fifo_data_r[rd_ptr_r][8*i +: 8];
        end
      end
    end
  end

  // Load-path state register.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Load-path next state: wait for blanking before touching the array.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_acc_s) begin
          state_s = RD_WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      RD_WAIT: begin
        if (blank) begin
          state_s = RD_RESP;
        end else begin
          state_s = RD_WAIT;
        end
      end
      RD_RESP: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Latch the load address on accept, sample the array at the blanking edge,
  // and flag out-of-region accepts one cycle later.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      ld_idx_r   <= '0;
      ld_inreg_r <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= 32'h0000_0000;
      err_r      <= 1'b0;
    end else begin
      if (load_acc_s) begin
        ld_idx_r   <= word_index(cpu_addr);
        ld_inreg_r <= in_region(cpu_addr);
      end
      rvalid_r <= (state_r == RD_WAIT) && blank;
      if ((state_r == RD_WAIT) && blank) begin
        rdata_r <= ld_inreg_r ? mem_r[ld_idx_r] : 32'h0000_0000;
      end
      err_r <= (push_s || load_acc_s) && !in_region(cpu_addr);
    end
  end

endmodule
